// File: rtl/sparse_reduce_unit.sv
// sparse_reduce_unit: folds innermost sparse fibers with add/max/min/count and re-emits stops one level lower via an output FIFO
module sparse_reduce_unit #(
  parameter int DATA_W = 16,
  parameter int OUT_DEPTH = 4,
  parameter logic [DATA_W-1:0] DONE_CODE = 'h0100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              tile_en,
  input  logic [1:0]        op_mode,
  input  logic              saturate,
  input  logic [DATA_W-1:0] default_value,
  input  logic [DATA_W:0]   data_in,
  input  logic              data_in_valid,
  output logic              data_in_ready,
  output logic [DATA_W:0]   data_out,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic              done_pulse
);
  localparam int AW = $clog2(OUT_DEPTH);
  typedef enum logic {RUN, DONE} state_t;
  state_t state, state_nx;
  logic [DATA_W:0] mem [OUT_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, free;
  logic [DATA_W-1:0] acc, acc_nx, v, sum, sat_sum, res;
  logic [DATA_W:0] w0, w1;
  logic [1:0] n_push;
  logic have_val, clr, accept, pop, is_tok, is_done, is_stop, ovf;
  assign clr = rst | flush;
  assign v = data_in[DATA_W-1:0];
  assign is_tok = data_in[DATA_W];
  assign is_done = is_tok & (v == DONE_CODE);
  assign is_stop = is_tok & ~is_done;
  assign accept = data_in_valid & data_in_ready;
  assign free = (AW+1)'(OUT_DEPTH) - count;
  assign data_out_valid = tile_en & (count != '0);
  assign pop = data_out_valid & data_out_ready;
  assign data_out = mem[rd_ptr];
  always_ff @(posedge clk)
    state <= clr ? RUN : state_nx;
  always_comb
    state_nx = (accept & is_done) ? DONE : state;
  always_comb
    data_in_ready = tile_en & (state == RUN) & (free >= (AW+1)'(2));
  always_comb begin
    sum = acc + v;
    ovf = (acc[DATA_W-1] == v[DATA_W-1]) & (sum[DATA_W-1] != acc[DATA_W-1]);
    sat_sum = acc[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    res = op_mode == 2'd0 ? ((saturate & ovf) ? sat_sum : sum) :
          op_mode == 2'd1 ? (($signed(v) > $signed(acc)) ? v : acc) :
          op_mode == 2'd2 ? (($signed(v) < $signed(acc)) ? v : acc) :
          (&acc ? acc : acc + DATA_W'(1));
    acc_nx = have_val ? res : (op_mode == 2'd3 ? DATA_W'(1) : v);
    w0 = is_done ? {1'b1, DONE_CODE} : {1'b0, have_val ? acc : default_value};
    w1 = {1'b1, DATA_W'(v[7:0] - 8'd1)};
    n_push = !(accept & is_tok) ? 2'd0 : (is_stop & (|v[7:0])) ? 2'd2 : 2'd1;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      acc <= '0;
      have_val <= 1'b0;
    end else if (accept) begin
      acc <= is_tok ? '0 : acc_nx;
      have_val <= ~is_tok;
    end
    done_pulse <= ~clr & accept & is_done;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (n_push != 2'd0) mem[wr_ptr] <= w0;
      if (n_push == 2'd2) mem[wr_ptr + AW'(1)] <= w1;
      wr_ptr <= wr_ptr + AW'(n_push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(n_push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_sparse_reduce_unit.sv
// tb_sparse_reduce_unit: table-driven directed bench for sparse_reduce_unit
module tb_sparse_reduce_unit;
  localparam logic [16:0] S0 = 17'h10000, S1 = 17'h10001, S2 = 17'h10002, D = 17'h10100;
  logic clk = 0, rst = 1, flush = 0, tile_en = 1, saturate = 0, data_in_valid = 0, data_out_ready = 1;
  logic [1:0] op_mode = 0;
  logic [15:0] default_value = 0;
  logic [16:0] data_in = 0, data_out;
  logic data_in_ready, data_out_valid, done_pulse;
  int total = 0, passed = 0, pulses = 0;
  logic [16:0] got [$];
  typedef struct packed {
    logic [1:0] op;
    logic sat;
    logic [15:0] def;
    int n_in;
    logic [0:5][16:0] in_w;
    int n_out;
    logic [0:3][16:0] out_w;
    int n_pulse;
  } vec_t;
  vec_t vecs [9];
  sparse_reduce_unit dut (
    .clk(clk), .rst(rst), .flush(flush), .tile_en(tile_en), .op_mode(op_mode),
    .saturate(saturate), .default_value(default_value), .data_in(data_in),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready), .data_out(data_out),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready), .done_pulse(done_pulse)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (data_out_valid && data_out_ready) got.push_back(data_out);
    if (done_pulse) pulses++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic send(input logic [16:0] w);
    int t = 0;
    data_in = w;
    data_in_valid = 1;
    @(negedge clk);
    while (!data_in_ready && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) begin
      total++;
      $display("FAIL send_timeout: word %h never accepted", w);
    end
    @(posedge clk);
    #1 data_in_valid = 0;
  endtask
  task automatic do_flush();
    @(posedge clk);
    #1 flush = 1;
    @(posedge clk);
    #1 flush = 0;
    got.delete();
    pulses = 0;
  endtask
  task automatic drain();
    data_out_ready = 1;
    repeat (8) @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string name, input int idx, input logic [16:0] exp);
    chk(name, idx < got.size() ? {15'd0, got[idx]} : 32'hdead, {15'd0, exp});
  endtask
  initial begin
    vecs[0] = '{op: 0, sat: 0, def: 16'h0, n_in: 6, in_w: {17'h3, 17'h4, S0, 17'h5, S1, D},
                n_out: 4, out_w: {17'h7, 17'h5, S0, D}, n_pulse: 1};
    vecs[1] = '{op: 0, sat: 0, def: 16'hFFFF, n_in: 3, in_w: {S0, S0, D, 17'h0, 17'h0, 17'h0},
                n_out: 3, out_w: {17'h0FFFF, 17'h0FFFF, D, 17'h0}, n_pulse: 1};
    vecs[2] = '{op: 0, sat: 1, def: 16'h0, n_in: 3, in_w: {17'h7FFF, 17'h1, S0, 17'h0, 17'h0, 17'h0},
                n_out: 1, out_w: {17'h07FFF, 17'h0, 17'h0, 17'h0}, n_pulse: 0};
    vecs[3] = '{op: 0, sat: 0, def: 16'h0, n_in: 3, in_w: {17'h7FFF, 17'h1, S0, 17'h0, 17'h0, 17'h0},
                n_out: 1, out_w: {17'h08000, 17'h0, 17'h0, 17'h0}, n_pulse: 0};
    vecs[4] = '{op: 1, sat: 0, def: 16'h0, n_in: 4, in_w: {17'hFFFE, 17'h3, 17'hFFFB, S0, 17'h0, 17'h0},
                n_out: 1, out_w: {17'h00003, 17'h0, 17'h0, 17'h0}, n_pulse: 0};
    vecs[5] = '{op: 2, sat: 0, def: 16'h0, n_in: 4, in_w: {17'hFFFE, 17'h3, 17'hFFFB, S0, 17'h0, 17'h0},
                n_out: 1, out_w: {17'h0FFFB, 17'h0, 17'h0, 17'h0}, n_pulse: 0};
    vecs[6] = '{op: 3, sat: 0, def: 16'h0, n_in: 4, in_w: {17'hFFFE, 17'h3, 17'hFFFB, S0, 17'h0, 17'h0},
                n_out: 1, out_w: {17'h00003, 17'h0, 17'h0, 17'h0}, n_pulse: 0};
    vecs[7] = '{op: 0, sat: 0, def: 16'h5, n_in: 3, in_w: {17'h9, S2, S1, 17'h0, 17'h0, 17'h0},
                n_out: 4, out_w: {17'h9, S1, 17'h5, S0}, n_pulse: 0};
    vecs[8] = '{op: 0, sat: 1, def: 16'h0, n_in: 3, in_w: {17'h8000, 17'hFFFF, S0, 17'h0, 17'h0, 17'h0},
                n_out: 1, out_w: {17'h08000, 17'h0, 17'h0, 17'h0}, n_pulse: 0};
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_out_valid", {31'd0, data_out_valid}, 0);
    chk("reset_in_ready", {31'd0, data_in_ready}, 1);
    chk("reset_data_out", {15'd0, data_out}, 0);
    chk("reset_done_pulse", {31'd0, done_pulse}, 0);
    for (int i = 0; i < 9; i++) begin
      do_flush();
      op_mode = vecs[i].op;
      saturate = vecs[i].sat;
      default_value = vecs[i].def;
      for (int j = 0; j < vecs[i].n_in; j++) send(vecs[i].in_w[j]);
      drain();
      chk($sformatf("v%0d_count", i), got.size(), vecs[i].n_out);
      chk($sformatf("v%0d_pulses", i), pulses, vecs[i].n_pulse);
      for (int j = 0; j < vecs[i].n_out; j++) chk_out($sformatf("v%0d_out%0d", i, j), j, vecs[i].out_w[j]);
    end
    do_flush();
    op_mode = 0;
    saturate = 0;
    default_value = 0;
    data_out_ready = 0;
    send(17'h1);
    send(S1);
    send(17'h2);
    send(S1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_ready_low", {31'd0, data_in_ready}, 0);
    end
    chk("bp_no_output", got.size(), 0);
    drain();
    chk("bp_count", got.size(), 4);
    chk_out("bp_out0", 0, 17'h1);
    chk_out("bp_out1", 1, S0);
    chk_out("bp_out2", 2, 17'h2);
    chk_out("bp_out3", 3, S0);
    do_flush();
    data_out_ready = 0;
    send(17'h3);
    send(S0);
    send(17'h4);
    #1 tile_en = 0;
    @(negedge clk);
    chk("te_ready_low", {31'd0, data_in_ready}, 0);
    chk("te_valid_low", {31'd0, data_out_valid}, 0);
    data_out_ready = 1;
    repeat (3) @(posedge clk);
    chk("te_frozen", got.size(), 0);
    #1 tile_en = 1;
    send(S0);
    drain();
    chk("te_count", got.size(), 2);
    chk_out("te_out0", 0, 17'h3);
    chk_out("te_out1", 1, 17'h4);
    do_flush();
    send(17'h3);
    send(17'h4);
    do_flush();
    send(17'h1);
    send(S0);
    send(D);
    drain();
    chk("fl_count", got.size(), 2);
    chk_out("fl_out0", 0, 17'h1);
    chk_out("fl_out1", 1, D);
    chk("fl_pulses", pulses, 1);
    data_in = 17'h5;
    data_in_valid = 1;
    repeat (5) begin
      @(negedge clk);
      chk("done_ready_low", {31'd0, data_in_ready}, 0);
    end
    chk("done_no_more_out", got.size(), 2);
    data_in_valid = 0;
    do_flush();
    @(negedge clk);
    chk("flush_ready_back", {31'd0, data_in_ready}, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
